// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : pipeline memory stage with fixed-latency data-memory access    |
// |             controller that stalls the pipeline through readyOut.          |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module mem_stage #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_ENIn,
  input  logic        MEM_R_ENIn,
  input  logic        MEM_W_ENIn,
  input  logic [31:0] ALU_ResIn,
  input  logic [31:0] Val_RmIn,
  input  logic [3:0]  DestIn,
  output logic        WB_ENOut,
  output logic        MEM_R_ENOut,
  output logic [31:0] ALU_ResOut,
  output logic [31:0] MemDataOut,
  output logic [3:0]  DestOut,
  output logic        readyOut
);

  localparam int         AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] C_CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           store_q, store_d;
  logic [31:0]    mem_data_q, mem_data_d;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           w_req;
  logic [AW-1:0]  w_idx;
  logic           w_ready;
  logic           w_mem_we;

  assign w_req = MEM_R_ENIn | MEM_W_ENIn;
  // Modular wrap falls out of keeping only the low index bits of the word offset.
  assign w_idx = AW'((ALU_ResIn - ADDR_BASE) >> 2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    store_d    = store_q;
    mem_data_d = mem_data_q;
    w_ready    = 1'b1;
    w_mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          w_ready = 1'b0;
          state_d = S_BUSY;
          cnt_d   = C_CNT_INIT;
          idx_d   = w_idx;
          wdata_d = Val_RmIn;
          store_d = MEM_W_ENIn;
        end
      end
      S_BUSY: begin
        w_ready = 1'b0;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (store_q) w_mem_we = 1'b1;
          else         mem_data_d = mem_q[idx_q];
        end
      end
      // Request inputs are still those of the finishing instruction here.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      store_q    <= 1'b0;
      mem_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Array deliberately has no reset; a reset forces IDLE first, so an aborted store never writes.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign readyOut    = w_ready;
  assign WB_ENOut    = WB_ENIn & w_ready;
  assign MEM_R_ENOut = MEM_R_ENIn & w_ready;
  assign ALU_ResOut  = ALU_ResIn;
  assign DestOut     = DestIn;
  assign MemDataOut  = mem_data_q;

endmodule
`default_nettype wire
